pal_dma_ctrl: RTL and testbench

- Sequences block copies from the palette staging buffer into the shared palette RAM.
- Drives the palette RAM write-side inputs (`ga21_addr`, `ga21_we`, `ga21_req`) and `dma_busy`, which take port priority over the CPU and pixel lookup.
- Arbitrates CPU palette accesses: they are stalled with a wait/ack handshake while a copy owns the RAM.
- A copy starts only during vertical blank, so active-display pixel lookup is never starved.

---
 rtl/pal_dma_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_pal_dma_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pal_dma_ctrl.sv
// Palette DMA sequencer: copies staging-buffer words into palette RAM during
// vertical blank and arbitrates CPU palette accesses against the copy.
module pal_dma_ctrl #(
   parameter int PAL_AW = 13,
   parameter int SRC_AW = 16,
   parameter int CNT_W  = 13
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vblank,
   input  logic              start,
   input  logic [SRC_AW-1:0] src_base,
   input  logic [PAL_AW-1:0] dst_base,
   input  logic [CNT_W-1:0]  count,
   output logic [SRC_AW-1:0] src_addr,
   output logic              src_rd,
   input  logic [15:0]       src_data,
   output logic [PAL_AW-1:0] pal_addr,
   output logic              pal_we,
   output logic [15:0]       pal_din,
   output logic              pal_req,
   output logic              dma_busy,
   input  logic              cpu_req,
   output logic              cpu_ack,
   output logic              cpu_wait,
   output logic              done
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARMED = 3'd1,
      COPY  = 3'd2,
      DRAIN = 3'd3,
      FIN   = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t state_r, state_s;

   logic [SRC_AW-1:0] src_base_r;
   logic [PAL_AW-1:0] dst_base_r;
   logic [CNT_W-1:0]  count_r;
   logic [CNT_W-1:0]  idx_r, idx_s;
   logic              ack_pend_r;

   logic              idle_or_armed_s;
   logic              latch_s;
   logic              grant_s;
   logic              last_s;
   logic [SRC_AW-1:0] src_eff_s;

   logic              src_rd_s, pal_we_s, busy_s, cpu_ack_s, done_s;
   logic [SRC_AW-1:0] src_addr_s;
   logic [PAL_AW-1:0] pal_addr_s;

   logic              src_rd_r, pal_we_r, busy_r, cpu_ack_r, done_r;
   logic [SRC_AW-1:0] src_addr_r;
   logic [PAL_AW-1:0] pal_addr_r;

   assign idle_or_armed_s = (state_r == IDLE) || (state_r == ARMED);
   assign latch_s         = start && idle_or_armed_s;
   // An ack stays outstanding until the CPU drops its request.
   assign grant_s         = cpu_req && !ack_pend_r && idle_or_armed_s;
   assign last_s          = (idx_r == (count_r - CNT_ONE));

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode; a CPU grant in ARMED holds off COPY entry by one cycle.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               if (count == CNT_ZERO) begin
                  state_s = FIN;
               end else begin
                  state_s = ARMED;
               end
            end else begin
               state_s = IDLE;
            end
         end
         ARMED: begin
            if (start && (count == CNT_ZERO)) begin
               state_s = FIN;
            end else if (grant_s) begin
               state_s = ARMED;
            end else if (vblank) begin
               state_s = COPY;
            end else begin
               state_s = ARMED;
            end
         end
         COPY: begin
            if (last_s) begin
               state_s = DRAIN;
            end else begin
               state_s = COPY;
            end
         end
         DRAIN:   state_s = FIN;
         FIN:     state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Output decode: next values of the registered outputs and the copy index.
   always_comb begin
      src_eff_s = latch_s ? src_base : src_base_r;
      if ((state_r == COPY) && (state_s == COPY)) begin
         idx_s = idx_r + CNT_ONE;
      end else begin
         idx_s = CNT_ZERO;
      end
      src_rd_s = (state_s == COPY);
      if (src_rd_s) begin
         src_addr_s = src_eff_s + SRC_AW'(idx_s);
      end else begin
         src_addr_s = {SRC_AW{1'b0}};
      end
      // The write for a read lands one cycle later, when its data arrives.
      pal_we_s = src_rd_r;
      if (src_rd_r) begin
         pal_addr_s = dst_base_r + PAL_AW'(idx_r);
      end else begin
         pal_addr_s = {PAL_AW{1'b0}};
      end
      busy_s    = (state_s == COPY) || (state_s == DRAIN);
      cpu_ack_s = grant_s;
      done_s    = (state_r == FIN);
   end

   // Copy parameters, index and CPU ack bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         src_base_r <= {SRC_AW{1'b0}};
         dst_base_r <= {PAL_AW{1'b0}};
         count_r    <= CNT_ZERO;
         idx_r      <= CNT_ZERO;
         ack_pend_r <= 1'b0;
      end else begin
         if (latch_s) begin
            src_base_r <= src_base;
            dst_base_r <= dst_base;
            count_r    <= count;
         end
         idx_r <= idx_s;
         if (grant_s) begin
            ack_pend_r <= 1'b1;
         end else if (!cpu_req) begin
            ack_pend_r <= 1'b0;
         end
      end
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         src_rd_r   <= 1'b0;
         src_addr_r <= {SRC_AW{1'b0}};
         pal_we_r   <= 1'b0;
         pal_addr_r <= {PAL_AW{1'b0}};
         busy_r     <= 1'b0;
         cpu_ack_r  <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         src_rd_r   <= src_rd_s;
         src_addr_r <= src_addr_s;
         pal_we_r   <= pal_we_s;
         pal_addr_r <= pal_addr_s;
         busy_r     <= busy_s;
         cpu_ack_r  <= cpu_ack_s;
         done_r     <= done_s;
      end
   end

   assign src_rd   = src_rd_r;
   assign src_addr = src_addr_r;
   assign pal_we   = pal_we_r;
   assign pal_addr = pal_addr_r;
   assign pal_din  = pal_we_r ? src_data : 16'h0000;
   assign pal_req  = busy_r;
   assign dma_busy = busy_r;
   assign cpu_ack  = cpu_ack_r;
   assign cpu_wait = cpu_req && !ack_pend_r &&
                     ((state_r == COPY) || (state_r == DRAIN) || (state_r == FIN));
   assign done     = done_r;

endmodule

// File: tb/tb_pal_dma_ctrl.sv
// Bench for pal_dma_ctrl: vector table of copies, random copies against a
// transaction-level model, and hand sequences for CPU contention and reset.
module tb_pal_dma_ctrl;

   logic        clk = 1'b0;
   logic        reset, vblank, start;
   logic [15:0] src_base;
   logic [12:0] dst_base;
   logic [12:0] count;
   logic [15:0] src_addr;
   logic        src_rd;
   logic [15:0] src_data;
   logic [12:0] pal_addr;
   logic        pal_we;
   logic [15:0] pal_din;
   logic        pal_req, dma_busy;
   logic        cpu_req, cpu_ack, cpu_wait, done;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   pal_dma_ctrl dut (
      .clk(clk), .reset(reset), .vblank(vblank), .start(start),
      .src_base(src_base), .dst_base(dst_base), .count(count),
      .src_addr(src_addr), .src_rd(src_rd), .src_data(src_data),
      .pal_addr(pal_addr), .pal_we(pal_we), .pal_din(pal_din),
      .pal_req(pal_req), .dma_busy(dma_busy),
      .cpu_req(cpu_req), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   // Staging buffer: data one cycle after the read strobe.
   always @(posedge clk) src_data <= src_rd ? mem_word(src_addr) : 16'hDEAD;

   // Monitor: cumulative counters, sampled on the falling edge.
   logic [28:0] wr_log [0:16383];
   int wr_total = 0, we_rises = 0, rd_rises = 0, busy_rises = 0, busy_total = 0;
   int done_total = 0, viol = 0, rd_rise_cyc = 0, we_rise_cyc = 0, busy_rise_cyc = 0;
   logic we_prev = 1'b0, rd_prev = 1'b0, busy_prev = 1'b0;

   always @(negedge clk) begin
      we_prev   <= pal_we;
      rd_prev   <= src_rd;
      busy_prev <= dma_busy;
      if (pal_we) begin
         wr_log[wr_total & 16383] <= {pal_addr, pal_din};
         wr_total <= wr_total + 1;
      end
      if (pal_we && !we_prev) begin
         we_rises <= we_rises + 1;
         we_rise_cyc <= cyc;
      end
      if (src_rd && !rd_prev) begin
         rd_rises <= rd_rises + 1;
         rd_rise_cyc <= cyc;
      end
      if (dma_busy && !busy_prev) begin
         busy_rises <= busy_rises + 1;
         busy_rise_cyc <= cyc;
      end
      if (dma_busy) busy_total <= busy_total + 1;
      if (done) done_total <= done_total + 1;
      if ((pal_we && !dma_busy) || (pal_req != dma_busy)) viol <= viol + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One complete copy, checked against the transaction model.
   task automatic run_copy(input logic [15:0] src, input logic [12:0] dst,
                           input logic [12:0] cnt, input int vd, input bit drop,
                           output int done_lat, output int nwr, output int nbusy,
                           output logic [12:0] fwa, output logic [12:0] lwa);
      int s, k, w0, we0, rd0, bs0, bt0, dn0, v0, first_rd;
      bit seen;
      w0 = wr_total; we0 = we_rises; rd0 = rd_rises; bs0 = busy_rises;
      bt0 = busy_total; dn0 = done_total; v0 = viol;
      src_base = src; dst_base = dst; count = cnt;
      vblank = (vd == 0); start = 1'b1;
      s = cyc; seen = 1'b0; done_lat = -1;
      tick();
      start = 1'b0;
      k = 1;
      while (!seen && k < 9000) begin
         if (k == vd) vblank = 1'b1;
         if (drop && src_rd) vblank = 1'b0;
         if (done) begin
            seen = 1'b1;
            done_lat = k;
         end
         tick();
         k++;
      end
      chk("done_seen", seen, 1);
      tick();
      tick();
      vblank = 1'b0;
      nwr   = wr_total - w0;
      nbusy = busy_total - bt0;
      chk("done_count", done_total - dn0, 1);
      chk("we_outside_busy", viol - v0, 0);
      if (cnt == 13'd0) begin
         chk("zero_rd", rd_rises - rd0, 0);
         chk("zero_busy", busy_rises - bs0, 0);
         chk("zero_we", nwr, 0);
      end else begin
         first_rd = s + ((vd + 1 > 2) ? vd + 1 : 2);
         chk("rd_start", rd_rise_cyc, first_rd);
         chk("busy_start", busy_rise_cyc, first_rd);
         chk("we_start", we_rise_cyc, first_rd + 1);
         chk("we_contiguous", we_rises - we0, 1);
         chk("busy_contiguous", busy_rises - bs0, 1);
         chk("nwr_model", nwr, cnt);
         for (int i = 0; i < int'(cnt) && i < nwr; i++) begin
            logic [12:0] ea;
            logic [15:0] sa;
            ea = dst + 13'(i);
            sa = src + 16'(i);
            chk("wr_entry", wr_log[(w0 + i) & 16383], {ea, mem_word(sa)});
         end
      end
      if (nwr > 0) begin
         fwa = wr_log[w0 & 16383][28:16];
         lwa = wr_log[(wr_total - 1) & 16383][28:16];
      end else begin
         fwa = 13'h0000;
         lwa = 13'h0000;
      end
   endtask

   typedef struct {
      logic [15:0] src;
      logic [12:0] dst;
      logic [12:0] cnt;
      int          vd;
      bit          drop;
      int          exp_lat;
      int          exp_nwr;
      int          exp_busy;
      logic [12:0] exp_fwa;
      logic [12:0] exp_lwa;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int lat, nwr, nbusy, k, nw;
      logic [12:0] fwa, lwa;
      bit saw;

      vecs[0] = '{16'h0100, 13'h0010, 13'd4,    0, 1'b0, 8,    4,    5,    13'h0010, 13'h0013};
      vecs[1] = '{16'h0200, 13'h0100, 13'd2,    5, 1'b1, 10,   2,    3,    13'h0100, 13'h0101};
      vecs[2] = '{16'hFFFE, 13'h1FFE, 13'd4,    0, 1'b0, 8,    4,    5,    13'h1FFE, 13'h0001};
      vecs[3] = '{16'h1234, 13'h0055, 13'd0,    0, 1'b0, 2,    0,    0,    13'h0000, 13'h0000};
      vecs[4] = '{16'h0007, 13'h1FFF, 13'd1,    1, 1'b0, 5,    1,    2,    13'h1FFF, 13'h1FFF};
      vecs[5] = '{16'h8000, 13'h0001, 13'd8191, 0, 1'b0, 8195, 8191, 8192, 13'h0001, 13'h1FFF};

      reset = 1'b1; vblank = 1'b0; start = 1'b0; cpu_req = 1'b0;
      src_base = 16'h0000; dst_base = 13'h0000; count = 13'd0;
      tick(); tick(); tick();
      chk("rst_src_rd", src_rd, 0);
      chk("rst_pal_we", pal_we, 0);
      chk("rst_busy", dma_busy, 0);
      chk("rst_req", pal_req, 0);
      chk("rst_ack", cpu_ack, 0);
      chk("rst_done", done, 0);
      chk("rst_wait", cpu_wait, 0);
      chk("rst_buses", {src_addr, pal_addr}, 0);
      chk("rst_din", pal_din, 0);
      reset = 1'b0;
      tick();

      foreach (vecs[v]) begin
         run_copy(vecs[v].src, vecs[v].dst, vecs[v].cnt, vecs[v].vd, vecs[v].drop,
                  lat, nwr, nbusy, fwa, lwa);
         chk("vec_done_lat", lat, vecs[v].exp_lat);
         chk("vec_nwr", nwr, vecs[v].exp_nwr);
         chk("vec_busy", nbusy, vecs[v].exp_busy);
         chk("vec_first_addr", fwa, vecs[v].exp_fwa);
         chk("vec_last_addr", lwa, vecs[v].exp_lwa);
      end

      for (int r = 0; r < 25; r++) begin
         logic [15:0] rs;
         logic [12:0] rd, rc;
         int rvd;
         bit rdrop;
         rs = 16'($urandom);
         rd = 13'($urandom);
         rc = 13'($urandom_range(0, 40));
         rvd = $urandom_range(0, 6);
         rdrop = 1'($urandom_range(0, 1));
         run_copy(rs, rd, rc, rvd, rdrop, lat, nwr, nbusy, fwa, lwa);
         chk("rnd_done_lat", lat, (rc == 13'd0) ? 2 : (((rvd + 1 > 2) ? rvd + 1 : 2) + int'(rc) + 2));
         chk("rnd_busy", nbusy, (rc == 13'd0) ? 0 : int'(rc) + 1);
         if (rc != 13'd0) chk("rnd_last_addr", lwa, rd + rc - 13'd1);
      end

      // CPU request raised during COPY: stalled until the copy ends.
      src_base = 16'h0300; dst_base = 13'h0300; count = 13'd6; vblank = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      cpu_req = 1'b1;
      tick();
      for (int c = 3; c <= 12; c++) begin
         chk("copy_cpu_wait", cpu_wait, (c <= 9));
         chk("copy_cpu_ack", cpu_ack, (c == 11));
         chk("copy_done", done, (c == 10));
         if (c == 11) cpu_req = 1'b0;
         tick();
      end
      vblank = 1'b0;
      tick();

      // CPU request coinciding with COPY entry wins; COPY starts a cycle later.
      src_base = 16'h0500; dst_base = 13'h0500; count = 13'd3; vblank = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      vblank = 1'b1;
      cpu_req = 1'b1;
      tick();
      chk("entry_ack", cpu_ack, 1);
      chk("entry_rd_held", src_rd, 0);
      chk("entry_busy_held", dma_busy, 0);
      cpu_req = 1'b0;
      tick();
      chk("entry_rd", src_rd, 1);
      chk("entry_ack_once", cpu_ack, 0);
      chk("entry_busy", dma_busy, 1);
      k = 0;
      while (!done && k < 20) begin
         tick();
         k++;
      end
      chk("entry_done", done, 1);
      chk("entry_done_lat", k, 5);
      vblank = 1'b0;
      tick();

      // CPU in IDLE: single ack per request, re-request after a low cycle.
      cpu_req = 1'b1;
      tick();
      chk("idle_ack", cpu_ack, 1);
      tick();
      chk("idle_no_reack", cpu_ack, 0);
      cpu_req = 1'b0;
      tick();
      chk("idle_ack_low", cpu_ack, 0);
      cpu_req = 1'b1;
      tick();
      chk("idle_reack", cpu_ack, 1);
      cpu_req = 1'b0;
      tick();

      // Reset during the third write of an eight-entry copy.
      src_base = 16'h0400; dst_base = 13'h0200; count = 13'd8; vblank = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      nw = 0;
      while (k < 50) begin
         if (pal_we) nw++;
         if (nw == 3) break;
         tick();
         k++;
      end
      chk("rst_reach_w3", nw, 3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      vblank = 1'b0;
      chk("midrst_we", pal_we, 0);
      chk("midrst_busy", {dma_busy, pal_req, src_rd}, 0);
      chk("midrst_buses", {src_addr, pal_addr, pal_din}, 0);
      saw = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (done || pal_we || dma_busy) saw = 1'b1;
         tick();
      end
      chk("midrst_quiet", saw, 0);
      run_copy(16'h0400, 13'h0200, 13'd8, 0, 1'b0, lat, nwr, nbusy, fwa, lwa);
      chk("post_rst_lat", lat, 12);
      chk("post_rst_nwr", nwr, 8);
      chk("post_rst_first", fwa, 13'h0200);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
